// File: rtl/serial_subtractor_32_pkg.sv
// ---------------------------------------------------------------------------
// sub_pkg -- shared definitions for the digit-serial subtractor.
//   state_e          : FSM encoding (IDLE / RUN / DONE)
//   num_slices()     : number of DIGIT-bit slices in a WIDTH-bit word
//   cnt_width()      : width of the slice counter (at least 1 bit)
// ---------------------------------------------------------------------------
package sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int num_slices(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_32_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_32_if -- request/result bundle of the serial subtractor.
//   start, x, y          : request side (driven by the master)
//   busy, done, d, bout, ovf : status/result side (driven by the slave)
// ---------------------------------------------------------------------------
interface serial_subtractor_32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;

  modport master (output start, x, y, input busy, done, d, bout, ovf);
  modport slave  (input start, x, y, output busy, done, d, bout, ovf);
endinterface

// File: rtl/serial_subtractor_32_digit_sub_slice.sv
// ---------------------------------------------------------------------------
// digit_sub_slice -- combinational DIGIT-bit subtract slice.
//   a, b : slice operands        cin  : incoming carry (1 = no borrow)
//   s    : a + ~b + cin (low DIGIT bits)   cout : carry out of the slice
// ---------------------------------------------------------------------------
module digit_sub_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);
  logic [DIGIT:0] sum;

  assign sum  = {1'b0, a} + {1'b0, ~b} + {{DIGIT{1'b0}}, cin};
  assign s    = sum[DIGIT-1:0];
  assign cout = sum[DIGIT];
endmodule

// File: rtl/serial_subtractor_32.sv
// ---------------------------------------------------------------------------
// serial_subtractor_32 -- multi-cycle d = x - y, one DIGIT-bit slice per clock,
// least-significant slice first.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of serial_subtractor_32_if
//           start/x/y in; busy (RUN), done (1-cycle pulse), d, bout, ovf out
// Results are held until the next accepted start.
// ---------------------------------------------------------------------------
module serial_subtractor_32
  import sub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_subtractor_32_if.slave bus
);
  localparam int N  = num_slices(WIDTH, DIGIT);
  localparam int CW = cnt_width(N);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  // Slice views of the captured operands, selected by the counter below.
  logic [DIGIT-1:0] x_slices [N];
  logic [DIGIT-1:0] y_slices [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_slices
    assign x_slices[gi] = x_q[gi*DIGIT +: DIGIT];
    assign y_slices[gi] = y_q[gi*DIGIT +: DIGIT];
  end

  logic [DIGIT-1:0] s_sel;
  logic             cout_sel;

  digit_sub_slice #(.DIGIT(DIGIT)) u_slice (
    .a    (x_slices[cnt_q]),
    .b    (y_slices[cnt_q]),
    .cin  (carry_q),
    .s    (s_sel),
    .cout (cout_sel)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          x_d     = bus.x;
          y_d     = bus.y;
          diff_d  = '0;
          cnt_d   = '0;
          carry_d = 1'b1;   // the "+1" of x + ~y + 1
          bout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < N; i++) begin
          if (cnt_q == CW'(i)) diff_d[i*DIGIT +: DIGIT] = s_sel;
        end
        carry_d = cout_sel;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(N-1)) begin
          // The top slice is being written now, so s_sel[DIGIT-1] is the
          // final sign bit of the difference.
          bout_d  = ~cout_sel;
          ovf_d   = (x_q[WIDTH-1] != y_q[WIDTH-1]) &&
                    (s_sel[DIGIT-1] != x_q[WIDTH-1]);
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = (state_q == ST_DONE);
  assign bus.d    = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: doc/serial_subtractor_32.md
Name: serial_subtractor_32

Overview:
Multi-cycle 32-bit subtractor computing d = x - y one DIGIT-bit slice per clock, least-significant slice first. It is the subtract-direction companion to the combinational 32-bit full adder in the adder/subtractor project. Operands are captured on a start handshake. The result, borrow-out and signed overflow are presented with a one-cycle done pulse, then held. Used where area matters more than latency, and as a cross-check against the combinational adder in benches.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of DIGIT
DIGIT, 4, bits processed per clock; number of slices N = WIDTH/DIGIT (8 by default)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
start  input  1  request; sampled only when ready (IDLE or DONE state)
x  input  WIDTH  minuend, captured on accepted start
y  input  WIDTH  subtrahend, captured on accepted start
busy  output  1  high while in RUN state
done  output  1  one-cycle pulse, result valid
d  output  WIDTH  difference x - y mod 2^WIDTH
bout  output  1  unsigned borrow-out (x < y unsigned)
ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; busy=0, done=0, d=0, bout=0, ovf=0; operand registers, slice counter and carry cleared. Reset wins over all other inputs, including mid-RUN; a pending operation is discarded and done is not raised.
- Arithmetic: d = x + ~y + 1. Internal carry is initialised to 1 on start. Each slice adds x_slice + ~y_slice + carry; the slice carry-out feeds the next slice.
  - bout = ~final carry-out.
  - ovf = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]), using captured operands.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on start=1, capture x and y, clear d, set counter=0 and carry=1, go to RUN. Otherwise stay.
  - RUN: each edge writes slice[counter] of d, updates carry, counter++. After the edge that writes slice N-1, go to DONE; bout and ovf are registered on that same edge. start is ignored in RUN.
  - DONE: done=1 for exactly this cycle. If start=1, capture new operands and go to RUN (back-to-back, no idle bubble). Otherwise go to IDLE.
- Latency: start accepted at edge E0; busy=1 after E0; done=1 and d/bout/ovf valid after edge E(N) (N cycles later).
- Throughput: one result per N+1 cycles with back-to-back starts.
- d, bout and ovf hold their value in IDLE until the next accepted start. Partial d during RUN is not valid, and consumers must use only done.
- x and y may change freely after the accepting edge; captured copies are used.
- busy and done are never high simultaneously.

Decomposition:
- Shared package sub_pkg: state encoding constants (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2) and the slice-count function N = WIDTH/DIGIT with counter width clog2(N).
- Sub-module digit_sub_slice: combinational DIGIT-bit slice with ports a, b, cin, s, cout; computes a + ~b + cin. Instantiated once and reused every cycle via the counter-selected slice mux.

Test Plan:
1. x=7, y=5, start pulse -> done exactly 8 cycles after accepting edge, d=32'h00000002, bout=0, ovf=0; busy high 8 cycles.
2. x=5, y=7 -> d=32'hFFFFFFFE, bout=1, ovf=0; then x=0, y=0 -> d=0, bout=0, ovf=0.
3. x=32'h80000000, y=1 -> d=32'h7FFFFFFF, bout=0, ovf=1; x=32'h7FFFFFFF, y=32'hFFFFFFFF -> d=32'h80000000, bout=1, ovf=1.
4. Start x=100, y=1, then assert start with x=9, y=9 during RUN cycle 3 -> ignored, result d=99; x/y changed after capture do not affect result.
5. start held high on the done cycle with x=32'h10, y=32'h20 -> no IDLE cycle; second done 9 cycles after first, d=32'hFFFFFFF0, bout=1.
6. rst_n=0 for one edge during RUN cycle 4 -> after that edge busy=0, done=0, d=0, no done pulse follows; next op x=3, y=1 -> d=2 after 8 cycles.
